// File: rtl/afc_ncntr_pkg.sv
// afc_pkg: FSM state encodings and count width shared by the AFC counter and controller
package afc_pkg;
   localparam int AFC_CNT_W = 14;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] COUNT = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;
endpackage

// File: rtl/afc_ncntr_if.sv
// afc_ncntr_if: counter control inputs and capture outputs between the AFC controller and the VCO counter
interface afc_ncntr_if import afc_pkg::*; #(parameter int CNT_W = AFC_CNT_W);
   logic afc_cntr_rstn;
   logic afc_cntr_en;
   logic afc_cntr_datasyn;
   logic vco_div;
   logic [CNT_W-1:0] a2d_afc_ncntr;
   logic ncntr_valid;
   logic ncntr_ovf;
   logic cnt_busy;
   modport master (
      output afc_cntr_rstn, afc_cntr_en, afc_cntr_datasyn, vco_div,
      input a2d_afc_ncntr, ncntr_valid, ncntr_ovf, cnt_busy
   );
   modport slave (
      input afc_cntr_rstn, afc_cntr_en, afc_cntr_datasyn, vco_div,
      output a2d_afc_ncntr, ncntr_valid, ncntr_ovf, cnt_busy
   );
endinterface

// File: rtl/afc_ncntr_sync_edge.sv
// afc_sync_edge: synchronizes an asynchronous square wave and flags its rising edges in the clk domain
module afc_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic edge_det
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic hist_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end
   assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;
endmodule

// File: rtl/afc_ncntr.sv
// afc_ncntr: counts divided-VCO rising edges inside the afc_cntr_en window and captures the count on request
module afc_ncntr import afc_pkg::*; #(
   parameter int CNT_W = AFC_CNT_W,
   parameter int SYNC_STAGES = 2
) (
   input logic clk,
   input logic rst,
   afc_ncntr_if.slave bus
);
   logic [1:0] state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, data_q, data_d;
   logic valid_q, valid_d, ovf_q, ovf_d;
   logic edge_det, inc, at_max, clr;
   afc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk),
      .rst(rst),
      .din(bus.vco_div),
      .edge_det(edge_det)
   );
   assign clr = ~bus.afc_cntr_rstn;
   assign inc = (state_q == COUNT) && edge_det && bus.afc_cntr_en;
   assign at_max = &cnt_q;
   // capture takes the post-increment value so a request never lags the live count
   always_comb begin
      state_d = clr ? IDLE : bus.afc_cntr_en ? COUNT : (state_q == IDLE) ? IDLE : HOLD;
      cnt_d = clr ? '0 : cnt_q + CNT_W'(inc && !at_max);
      ovf_d = clr ? 1'b0 : ovf_q | (inc & at_max);
      valid_d = ~clr & bus.afc_cntr_datasyn;
      data_d = clr ? '0 : bus.afc_cntr_datasyn ? cnt_d : data_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         data_q <= '0;
         valid_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         data_q <= data_d;
         valid_q <= valid_d;
         ovf_q <= ovf_d;
      end
   end
   assign bus.a2d_afc_ncntr = data_q;
   assign bus.ncntr_valid = valid_q;
   assign bus.ncntr_ovf = ovf_q;
   assign bus.cnt_busy = (state_q == COUNT);
endmodule

// File: tb/tb_afc_ncntr.sv
// tb_afc_ncntr: directed scenarios for the VCO counter with hand-computed capture values
module tb_afc_ncntr;
   import afc_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_checks = 0;
   int n_fail = 0;
   int vco_half = 0;
   int ph = 0;
   afc_ncntr_if bus ();
   afc_ncntr dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;

   // all stimulus, including the VCO wave, advances on falling edges so posedge sampling is unambiguous
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         if (vco_half != 0) begin
            ph++;
            if (ph == vco_half) begin
               ph = 0;
               bus.vco_div = ~bus.vco_div;
            end
         end
      end
   endtask

   task automatic start_vco(input int half);
      ph = 0;
      vco_half = half;
   endtask

   task automatic clear_block();
      vco_half = 0;
      bus.vco_div = 1'b0;
      bus.afc_cntr_en = 1'b0;
      bus.afc_cntr_datasyn = 1'b0;
      bus.afc_cntr_rstn = 1'b0;
      step(4);
      bus.afc_cntr_rstn = 1'b1;
      step(1);
   endtask

   task automatic capture();
      bus.afc_cntr_datasyn = 1'b1;
      step(1);
      bus.afc_cntr_datasyn = 1'b0;
   endtask

   task automatic test_reset();
      bus.afc_cntr_rstn = 1'b1;
      bus.afc_cntr_en = 1'b0;
      bus.afc_cntr_datasyn = 1'b0;
      bus.vco_div = 1'b0;
      step(3);
      n_checks++; if (bus.a2d_afc_ncntr !== 14'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", bus.a2d_afc_ncntr); end
      n_checks++; if (bus.ncntr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.ncntr_valid); end
      n_checks++; if (bus.ncntr_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.ncntr_ovf); end
      n_checks++; if (bus.cnt_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.cnt_busy); end
      rst = 1'b0;
      step(2);
      n_checks++; if (bus.cnt_busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got %b expected 0", bus.cnt_busy); end
   endtask

   task automatic test_basic_count();
      clear_block();
      start_vco(4);
      bus.afc_cntr_en = 1'b1;
      step(152);
      n_checks++; if (bus.cnt_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", bus.cnt_busy); end
      bus.afc_cntr_en = 1'b0;
      capture();
      n_checks++; if (bus.a2d_afc_ncntr !== 14'd19) begin n_fail++; $display("FAIL basic_count: got %0d expected 19", bus.a2d_afc_ncntr); end
      n_checks++; if (bus.ncntr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_hi: got %b expected 1", bus.ncntr_valid); end
      step(1);
      n_checks++; if (bus.ncntr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_lo: got %b expected 0", bus.ncntr_valid); end
      n_checks++; if (bus.ncntr_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b expected 0", bus.ncntr_ovf); end
      n_checks++; if (bus.cnt_busy !== 1'b0) begin n_fail++; $display("FAIL basic_hold_busy: got %b expected 0", bus.cnt_busy); end
   endtask

   task automatic test_saturate();
      clear_block();
      start_vco(2);
      bus.afc_cntr_en = 1'b1;
      step(70000);
      n_checks++; if (bus.ncntr_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b expected 1", bus.ncntr_ovf); end
      bus.afc_cntr_en = 1'b0;
      capture();
      n_checks++; if (bus.a2d_afc_ncntr !== 14'd16383) begin n_fail++; $display("FAIL sat_count: got %0d expected 16383", bus.a2d_afc_ncntr); end
      n_checks++; if (bus.ncntr_valid !== 1'b1) begin n_fail++; $display("FAIL sat_valid: got %b expected 1", bus.ncntr_valid); end
   endtask

   task automatic test_hold();
      clear_block();
      n_checks++; if (bus.ncntr_ovf !== 1'b0) begin n_fail++; $display("FAIL clear_ovf: got %b expected 0", bus.ncntr_ovf); end
      start_vco(4);
      bus.afc_cntr_en = 1'b1;
      step(80);
      bus.afc_cntr_en = 1'b0;
      step(20);
      capture();
      n_checks++; if (bus.a2d_afc_ncntr !== 14'd10) begin n_fail++; $display("FAIL hold_mid_count: got %0d expected 10", bus.a2d_afc_ncntr); end
      n_checks++; if (bus.cnt_busy !== 1'b0) begin n_fail++; $display("FAIL hold_busy: got %b expected 0", bus.cnt_busy); end
      step(19);
      bus.afc_cntr_en = 1'b1;
      step(80);
      bus.afc_cntr_en = 1'b0;
      capture();
      n_checks++; if (bus.a2d_afc_ncntr !== 14'd20) begin n_fail++; $display("FAIL hold_total: got %0d expected 20", bus.a2d_afc_ncntr); end
   endtask

   task automatic test_rstn_vs_datasyn();
      clear_block();
      start_vco(2);
      bus.afc_cntr_en = 1'b1;
      step(201);
      capture();
      n_checks++; if (bus.a2d_afc_ncntr !== 14'd50) begin n_fail++; $display("FAIL pre_clear_count: got %0d expected 50", bus.a2d_afc_ncntr); end
      n_checks++; if (bus.cnt_busy !== 1'b1) begin n_fail++; $display("FAIL pre_clear_busy: got %b expected 1", bus.cnt_busy); end
      bus.afc_cntr_en = 1'b0;
      bus.afc_cntr_rstn = 1'b0;
      bus.afc_cntr_datasyn = 1'b1;
      step(1);
      n_checks++; if (bus.a2d_afc_ncntr !== 14'd0) begin n_fail++; $display("FAIL clear_data: got %0d expected 0", bus.a2d_afc_ncntr); end
      n_checks++; if (bus.ncntr_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid: got %b expected 0", bus.ncntr_valid); end
      n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL clear_state: got %0d expected %0d", dut.state_q, IDLE); end
      bus.afc_cntr_rstn = 1'b1;
      bus.afc_cntr_datasyn = 1'b0;
      step(1);
      n_checks++; if (bus.ncntr_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid_after: got %b expected 0", bus.ncntr_valid); end
   endtask

   task automatic test_back_to_back();
      clear_block();
      start_vco(4);
      bus.afc_cntr_en = 1'b1;
      step(80);
      capture();
      n_checks++; if (bus.a2d_afc_ncntr !== 14'd10) begin n_fail++; $display("FAIL b2b_first: got %0d expected 10", bus.a2d_afc_ncntr); end
      n_checks++; if (bus.cnt_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy1: got %b expected 1", bus.cnt_busy); end
      step(1);
      n_checks++; if (bus.ncntr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_valid: got %b expected 0", bus.ncntr_valid); end
      step(14);
      bus.afc_cntr_datasyn = 1'b1;
      step(1);
      n_checks++; if (bus.a2d_afc_ncntr !== 14'd12) begin n_fail++; $display("FAIL b2b_second: got %0d expected 12", bus.a2d_afc_ncntr); end
      n_checks++; if (bus.cnt_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy2: got %b expected 1", bus.cnt_busy); end
      step(1);
      bus.afc_cntr_datasyn = 1'b0;
      n_checks++; if (bus.ncntr_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_run: got %b expected 1", bus.ncntr_valid); end
      n_checks++; if (bus.a2d_afc_ncntr !== 14'd12) begin n_fail++; $display("FAIL b2b_third: got %0d expected 12", bus.a2d_afc_ncntr); end
      step(1);
      n_checks++; if (bus.ncntr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_end: got %b expected 0", bus.ncntr_valid); end
   endtask

   task automatic test_async_rst();
      clear_block();
      start_vco(2);
      bus.afc_cntr_en = 1'b1;
      step(122);
      capture();
      n_checks++; if (bus.a2d_afc_ncntr !== 14'd30) begin n_fail++; $display("FAIL rst_pre_count: got %0d expected 30", bus.a2d_afc_ncntr); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (bus.a2d_afc_ncntr !== 14'd0) begin n_fail++; $display("FAIL rst_async_data: got %0d expected 0", bus.a2d_afc_ncntr); end
      n_checks++; if (bus.ncntr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 0", bus.ncntr_valid); end
      n_checks++; if (bus.cnt_busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b expected 0", bus.cnt_busy); end
      vco_half = 0;
      bus.vco_div = 1'b0;
      bus.afc_cntr_en = 1'b0;
      step(3);
      rst = 1'b0;
      step(4);
      n_checks++; if (bus.cnt_busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got %b expected 0", bus.cnt_busy); end
      start_vco(4);
      bus.afc_cntr_en = 1'b1;
      step(152);
      bus.afc_cntr_en = 1'b0;
      capture();
      n_checks++; if (bus.a2d_afc_ncntr !== 14'd19) begin n_fail++; $display("FAIL rst_recount: got %0d expected 19", bus.a2d_afc_ncntr); end
   endtask

   initial begin
      test_reset();
      test_basic_count();
      test_saturate();
      test_hold();
      test_rstn_vs_datasyn();
      test_back_to_back();
      test_async_rst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
